// File: rtl/button_command_scheduler.sv
// button_command_scheduler
//   Turns debounced, mutually exclusive button levels into a queue of 2-bit command codes
//   and hands them to the command consumer over a valid/ready handshake.
//   Press-edge detection, FIFO_DEPTH-entry command FIFO, sticky overflow flag.
//   Optional hold-to-repeat, built only when BUTTON_CMD_AUTO_REPEAT_EN is defined.
//
// Ports
//   i_clk_mhz    system clock
//   i_rst_mhz    synchronous reset, active high
//   i_btns_deb   debounced button levels (one-hot or zero; anything else reads as zero)
//   i_cmd_ready  consumer takes the head command this cycle
//   o_cmd_valid  FIFO non-empty, o_cmd_code valid
//   o_cmd_code   head command: index of the pressed button
//   o_fifo_full  FIFO holds FIFO_DEPTH entries
//   o_overflow   sticky: a command was dropped since reset
module button_command_scheduler #(
  parameter int unsigned FCLK            = 20000000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic       i_clk_mhz,
  input  logic       i_rst_mhz,
  input  logic [3:0] i_btns_deb,
  input  logic       i_cmd_ready,
  output logic       o_cmd_valid,
  output logic [1:0] o_cmd_code,
  output logic       o_fifo_full,
  output logic       o_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Input legalisation and press-edge detection
  logic [3:0] btns_legal;
  logic [3:0] prev_q;
  logic       press_evt;
  logic [1:0] btn_code;

  assign btns_legal = $onehot0(i_btns_deb) ? i_btns_deb : 4'b0000;
  assign press_evt  = (btns_legal != 4'b0000) && (btns_legal != prev_q);

  always_comb begin
    btn_code = 2'd0;
    case (btns_legal)
      4'b0010: btn_code = 2'd1;
      4'b0100: btn_code = 2'd2;
      4'b1000: btn_code = 2'd3;
      default: btn_code = 2'd0;
    endcase
  end

  logic repeat_evt;

`ifdef BUTTON_CMD_AUTO_REPEAT_EN
  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} hold_state_e;

  localparam int unsigned DelayCyc = FCLK / 1000 * REPEAT_DELAY_MS;
  localparam int unsigned RateCyc  = FCLK / 1000 * REPEAT_RATE_MS;
  localparam int unsigned MaxCyc   = (DelayCyc > RateCyc) ? DelayCyc : RateCyc;
  localparam int unsigned TimerW   = (MaxCyc > 1) ? $clog2(MaxCyc + 1) : 1;

  hold_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              btn_changed;

  assign btn_changed = (btns_legal != prev_q);

  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == {TimerW{1'b1}}) ? timer_q : timer_q + TimerW'(1);
    repeat_evt = 1'b0;
    case (state_q)
      StIdle: begin
        if (press_evt) begin
          state_d = StHeld;
          timer_d = '0;
        end
      end
      StHeld: begin
        // A switch to another button drops to idle; its press event is pushed normally.
        if (btn_changed) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q == TimerW'(DelayCyc - 1)) begin
          repeat_evt = 1'b1;
          state_d    = StRepeat;
          timer_d    = '0;
        end
      end
      StRepeat: begin
        if (btn_changed) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q == TimerW'(RateCyc - 1)) begin
          repeat_evt = 1'b1;
          timer_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end
`else
  assign repeat_evt = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{FCLK, REPEAT_DELAY_MS, REPEAT_RATE_MS};
`endif

  // Command FIFO
  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;
  logic            fifo_empty, fifo_full;
  logic            push_req, push, pop, drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && i_cmd_ready;
  // A repeat only fires while the held button is unchanged, so btn_code is the held code.
  assign push_req   = press_evt || repeat_evt;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      prev_q     <= 4'b0000;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 2'd0;
      end
    end else begin
      prev_q <= btns_legal;
      if (push) begin
        mem_q[wptr_q] <= btn_code;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign o_cmd_valid = !fifo_empty;
  assign o_cmd_code  = mem_q[rptr_q];
  assign o_fifo_full = fifo_full;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_button_command_scheduler.sv
// Testbench for button_command_scheduler: directed scenarios plus randomized button/ready
// traffic, all checked against a queue-based reference model.
// Auto-repeat expectations are enabled when BUTTON_CMD_AUTO_REPEAT_EN is defined.
module tb_button_command_scheduler;

  localparam int unsigned Depth     = 4;
  localparam int          DelayCyc  = 50;  // 5 ms at 10 cycles/ms
  localparam int          RateCyc   = 20;  // 2 ms at 10 cycles/ms

  logic       clk;
  logic       rst;
  logic [3:0] btns;
  logic       ready;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       fifo_full;
  logic       overflow;

  int tests_run;
  int tests_failed;

  button_command_scheduler #(
    .FCLK           (10000),
    .FIFO_DEPTH     (Depth),
    .REPEAT_DELAY_MS(5),
    .REPEAT_RATE_MS (2)
  ) dut (
    .i_clk_mhz  (clk),
    .i_rst_mhz  (rst),
    .i_btns_deb (btns),
    .i_cmd_ready(ready),
    .o_cmd_valid(cmd_valid),
    .o_cmd_code (cmd_code),
    .o_fifo_full(fifo_full),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int         m_q[$];
  bit         m_ovf;
  logic [3:0] m_prev;
  bit         m_hold;
  bit         m_first;
  int         m_age;
  int         m_hcode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_update(input logic [3:0] b, input logic r, input logic rs);
    logic [3:0] legal;
    bit         press, rep, changed, do_pop;
    int         code, size0;
    if (rs) begin
      m_q.delete();
      m_ovf  = 0;
      m_prev = 4'b0000;
      m_hold = 0;
      m_age  = 0;
      return;
    end
    legal   = ((b == 4'b0000) || $onehot(b)) ? b : 4'b0000;
    changed = (legal != m_prev);
    press   = (legal != 4'b0000) && changed;
    code    = idx_of(legal);
    rep     = 0;
`ifdef BUTTON_CMD_AUTO_REPEAT_EN
    if (m_hold) begin
      if (changed) begin
        m_hold = 0;
      end else begin
        m_age++;
        if (m_age == (m_first ? DelayCyc : RateCyc)) begin
          rep     = 1;
          m_age   = 0;
          m_first = 0;
        end
      end
    end else if (press) begin
      m_hold  = 1;
      m_first = 1;
      m_age   = 0;
      m_hcode = code;
    end
    if (rep) code = m_hcode;
`endif
    size0  = m_q.size();
    do_pop = (size0 > 0) && r;
    if (do_pop) void'(m_q.pop_front());
    if (press || rep) begin
      if (size0 < int'(Depth) || do_pop) m_q.push_back(code);
      else m_ovf = 1;
    end
    m_prev = legal;
  endtask

  task automatic step(input logic [3:0] b, input logic r, input logic rs);
    btns  = b;
    ready = r;
    rst   = rs;
    @(posedge clk);
    model_update(b, r, rs);
    #1;
    check_eq("valid", cmd_valid, m_q.size() != 0);
    check_eq("full", fifo_full, m_q.size() == int'(Depth));
    check_eq("overflow", overflow, m_ovf);
    if (m_q.size() != 0) check_eq("code", cmd_code, m_q[0]);
  endtask

  int n_cmds;
  int exp_cmds;

  initial begin
    logic [3:0] rb;
    logic [3:0] cur;
    int         hold_left;
    int         sel;
    tests_run    = 0;
    tests_failed = 0;
    btns         = 4'b0000;
    ready        = 1'b0;
    rst          = 1'b1;
    m_prev       = 4'b0000;
    m_ovf        = 0;
    m_hold       = 0;

    // Reset state
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    check_eq("rst_code", cmd_code, 0);

    // Press and consume, then hold
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    check_eq("press_valid", cmd_valid, 1);
    check_eq("press_code", cmd_code, 2);
    n_cmds = 1;
    for (int i = 1; i < 100; i++) begin
      step(4'b0100, 1'b1, 1'b0);
      if (cmd_valid) n_cmds++;
    end
`ifdef BUTTON_CMD_AUTO_REPEAT_EN
    exp_cmds = 4;
`else
    exp_cmds = 1;
`endif
    check_eq("hold_cmds", n_cmds, exp_cmds);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);

    // Backpressure, full, overflow, ordered drain
    step(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      rb = 4'b0001 << c;
      step(rb, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
    end
    check_eq("bp_full", fifo_full, 1);
    check_eq("bp_no_ovf", overflow, 0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check_eq("bp_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_code", cmd_code, i);
      step(4'b0000, 1'b1, 1'b0);
    end
    check_eq("drain_empty", cmd_valid, 0);
    check_eq("ovf_sticky", overflow, 1);

    // Simultaneous push and pop at full
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0); step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0); step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0); step(4'b0000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0); step(4'b0000, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    check_eq("pp_full", fifo_full, 1);
    check_eq("pp_no_ovf", overflow, 0);
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("pp_code", cmd_code, (i == 3) ? 0 : ((i == 0) ? 2 : ((i == 1) ? 1 : 3)));
      step(4'b0000, 1'b1, 1'b0);
    end

    // Illegal (multi-hot) input
    step(4'b0110, 1'b1, 1'b0);
    check_eq("illegal_valid", cmd_valid, 0);
    step(4'b0000, 1'b1, 1'b0);
    check_eq("illegal_valid2", cmd_valid, 0);

    // Reset mid-operation
    step(4'b0001, 1'b0, 1'b0); step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0); step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0); step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    check_eq("mid_rst_valid", cmd_valid, 0);
    check_eq("mid_rst_full", fifo_full, 0);
    check_eq("mid_rst_ovf", overflow, 0);
    step(4'b1000, 1'b0, 1'b0);
    check_eq("post_rst_valid", cmd_valid, 1);
    check_eq("post_rst_code", cmd_code, 3);

    // Randomized traffic
    cur       = 4'b0000;
    hold_left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold_left == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 3) begin
          cur = 4'b0000;
        end else if (sel < 8) begin
          rb  = 4'b0001 << $urandom_range(0, 3);
          cur = rb;
        end else if (sel == 8) begin
          rb  = 4'($urandom_range(0, 15));
          cur = rb | 4'b0011;
        end
        hold_left = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 130)
                                                : $urandom_range(1, 8);
      end
      hold_left--;
      step(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/button_command_scheduler.md
Name: button_command_scheduler

Overview:
- Converts the 4-bit debounced, mutually exclusive button levels into a queue of 2-bit command codes.
- Hands the commands to the ACL-tester command consumer (the mode/measurement sequencer) over a valid/ready handshake.
- Sits between the multi-button debouncer and the consumer. Provides press-edge detection, a small command FIFO, overflow flagging and optional hold-to-repeat.

Parameters:
- FCLK, 20000000, system clock frequency in Hz.
- FIFO_DEPTH, 4, number of command entries; power of two, 2..16.
- REPEAT_DELAY_MS, 500, hold time in ms before the first auto-repeat.
- REPEAT_RATE_MS, 100, interval in ms between subsequent auto-repeats.

Ports:
- i_clk_mhz  in  1  system clock.
- i_rst_mhz  in  1  synchronous reset, active-high.
- i_btns_deb  in  4  debounced button levels; one-hot or zero.
- i_cmd_ready  in  1  consumer accepts the head command this cycle.
- o_cmd_valid  out  1  FIFO non-empty; o_cmd_code is valid.
- o_cmd_code  out  2  index of the pressed button (bit0 -> 0 ... bit3 -> 3).
- o_fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- o_overflow  out  1  sticky: a command was dropped.

Behaviour:
- Reset (synchronous, i_rst_mhz=1 at a clock edge): FIFO empty; read and write pointers 0. o_cmd_valid=0, o_cmd_code=0, o_fifo_full=0, o_overflow=0. Previous-button register=0000, FSM=ST_IDLE, timer=0. Reset mid-operation discards all queued commands.
- Input legality: i_btns_deb values that are neither zero nor one-hot are treated as 0000.
- Edge detect: prev <= legalised i_btns_deb every cycle. A press event occurs when the current one-hot value is nonzero and differs from prev, including a direct one-hot to different one-hot change.
- Push: a press event (or repeat event) writes the code at that clock edge. o_cmd_valid rises the following cycle, giving 1-cycle latency.
- Pop: when o_cmd_valid and i_cmd_ready are both 1 at a clock edge, the head advances.
- o_cmd_code: driven from the FIFO head register. It is stable while o_cmd_valid=1 and i_cmd_ready=0.
- Full, no pop, push requested: the command is dropped and o_overflow is set until reset.
- Full, with pop and push in the same cycle: both are performed; occupancy is unchanged and there is no overflow.
- Empty, with push only: occupancy becomes 1. A pop is never accepted while empty.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- Hold FSM, used only when the feature below is enabled:
  - ST_IDLE: on a press event go to ST_HELD and clear the timer.
  - ST_HELD: if the button changes (release or a different button), go to ST_IDLE. A different button also produces a normal press event. When the timer reaches FCLK/1000*REPEAT_DELAY_MS-1, push a repeat of the held code, clear the timer and go to ST_REPEAT.
  - ST_REPEAT: a button change is handled as in ST_HELD. When the timer reaches FCLK/1000*REPEAT_RATE_MS-1, push a repeat and clear the timer.
  - Timer: saturating counter, cleared on every state change.
  - Repeat pushes follow the same overflow rules as press pushes.

Optional Feature:
- Macro BUTTON_CMD_AUTO_REPEAT_EN.
- Defined: the hold FSM and timer are built; a held button produces repeat commands as described above.
- Undefined: the FSM and timer are omitted. Only press events push commands, and holding a button indefinitely yields exactly one command.

Test Plan:
All scenarios use FCLK=10000 (10 cycles/ms), FIFO_DEPTH=4, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2.
- Press and consume: i_btns_deb 0000->0100 with i_cmd_ready=1 -> o_cmd_valid high for exactly 1 cycle, 1 cycle after the edge, with o_cmd_code=2. Holding causes no further push with the macro undefined.
- Backpressure and full: i_cmd_ready=0; press codes 0,1,2,3 with releases in between -> o_fifo_full=1 and o_overflow=0. A fifth press (code 1) -> o_overflow=1. Then raise ready -> codes 0,1,2,3 pop in order, and the overflow flag stays 1.
- Simultaneous push/pop at full: FIFO full, ready=1 in the same cycle as a new press of code 0 -> occupancy stays 4, o_overflow=0, and code 0 becomes the last entry.
- Illegal input: i_btns_deb=0110 then 0000 -> no command is pushed and o_cmd_valid stays 0.
- Auto-repeat (macro defined): hold 0001 for 100 cycles with ready=1 -> commands at edge+1 (press), edge+51, +71, +91, all code 0. Release -> no more pushes.
- Reset mid-operation: with 3 queued entries, assert i_rst_mhz for 1 cycle -> the next cycle shows o_cmd_valid=0, o_fifo_full=0 and o_overflow=0. A subsequent press is accepted normally.
